dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage data port.
- Accepts load/store requests (address, write data, read/write strobes) and services them from an internal word-addressed RAM with a programmable access latency.
- Returns load data and drives a stall to freeze the pipeline for the duration of the access.
- Sits between the MEM stage (ALUOutM/WriteDataM producer) and the WB pipeline register (ReadDataM consumer).

---
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the MEM-stage data port. A load or store is
// accepted in IDLE. It is held for LATENCY BUSY cycles and is then reported
// with a one-cycle rvalid pulse (DONE). The pipeline is frozen through stall
// from the accept cycle until the last BUSY cycle.
//
// Optional feature (macro DMEM_ALIGN_CHECK_EN):
//   When the macro is defined, a misalign output is added. Accesses whose
//   byte address is not word aligned are suppressed: there is no RAM write
//   and rdata is cleared. misalign pulses together with rvalid.
//
// Parameters:
//   ADDR_W   log2 of RAM depth in 32-bit words
//   LATENCY  BUSY cycles per access, legal range 1..15
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high reset
//   memread   load request
//   memwrite  store request (wins when both strobes are high)
//   addr      byte address; word index is addr[ADDR_W+1:2]
//   wdata     store data
//   rdata     registered load data, held until the next completed read
//   rvalid    one-cycle pulse when an access completes
//   stall     pipeline freeze request
//   misalign  misaligned-access flag (DMEM_ALIGN_CHECK_EN only)
//
// Handshake: a request is taken when the block is IDLE and memread|memwrite
// is high. The requester keeps its strobes up while stall is high. In the
// DONE cycle stall drops and rvalid is high. The request inputs are not
// sampled in that cycle, so the completed request can leave MEM without
// being taken a second time.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q;
    state_t            state_d;
    logic              req;
    logic              accept;
    logic              access_now;
    logic              suppress;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              op_write_q;
    logic [31:0]       mem [0:(2**ADDR_W)-1];

    // Address bits above the RAM index alias onto the same words.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign req        = memread | memwrite;
    assign accept     = (state_q == IDLE) && req;
    assign access_now = (state_q == BUSY) && (cnt_q == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q;
    assign suppress = mis_q;
`else
    assign suppress = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. stall is raised in the accept cycle itself, so the MEM
    // stage freezes before the next edge.
    always_comb begin
        stall  = 1'b0;
        rvalid = 1'b0;
        case (state_q)
            IDLE:    stall  = req;
            BUSY:    stall  = 1'b1;
            DONE:    rvalid = 1'b1;
            default: ;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = (state_q == DONE) && mis_q;
`endif

    // Request latch, latency counter and read-data register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            rdata      <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                idx_q      <= addr[ADDR_W+1:2];
                wdata_q    <= wdata;
                op_write_q <= memwrite;
                cnt_q      <= CNT_INIT;
`ifdef DMEM_ALIGN_CHECK_EN
                mis_q      <= (addr[1:0] != 2'b00);
`endif
            end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            // A suppressed access clears rdata for loads and stores alike.
            // A normal store leaves rdata untouched.
            if (access_now) begin
                if (suppress)         rdata <= 32'd0;
                else if (!op_write_q) rdata <= mem[idx_q];
            end
        end
    end

    // RAM write port. The RAM has no reset. A reset that lands on the access
    // cycle discards the pending store.
    always_ff @(posedge clk) begin
        if (!reset && access_now && op_write_q && !suppress)
            mem[idx_q] <= wdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder with the default parameters
// (ADDR_W=6, LATENCY=2). It keeps a reference memory model. The expected
// rdata of each access is queued when the access is issued. It is popped and
// compared in the cycle where rvalid is due. Compile with
// +define+DMEM_ALIGN_CHECK_EN to include the misalignment steps.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int ADDR_W  = 6;
    localparam int LATENCY = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset    = 1'b1;
    logic        memread  = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr     = 32'd0;
    logic [31:0] wdata    = 32'd0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk      (clk),
        .reset    (reset),
        .memread  (memread),
        .memwrite (memwrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .stall    (stall)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .misalign (misalign)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [0:(2**ADDR_W)-1];
    logic [31:0] model_rdata = 32'd0;
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_mis(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a[1:0] != 2'b00);
`else
        return 1'b0 & a[0];
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // One complete access. The request is presented just after a falling
    // edge and held through DONE. addr/wdata are scrambled during BUSY to
    // show that the latched copies are used.
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp;
        logic [31:0] got_exp;
        logic        mis;
        logic [ADDR_W-1:0] idx;
        idx = a[ADDR_W+1:2];
        mis = exp_mis(a);
        if (mis)     exp = 32'd0;
        else if (wr) begin
            model_mem[idx] = d;
            exp = model_rdata;
        end else     exp = model_mem[idx];
        model_rdata = exp;
        exp_q.push_back(exp);

        @(negedge clk);
        memread = rd; memwrite = wr; addr = a; wdata = d;
        #1;
        check("stall_accept", {31'd0, stall}, 32'd1);
        check("rvalid_accept", {31'd0, rvalid}, 32'd0);
        for (int k = 1; k <= LATENCY; k++) begin
            @(negedge clk);
            check("stall_busy", {31'd0, stall}, 32'd1);
            check("rvalid_busy", {31'd0, rvalid}, 32'd0);
            addr  = $urandom;
            wdata = $urandom;
        end
        @(negedge clk);
        got_exp = exp_q.pop_front();
        check("stall_done", {31'd0, stall}, 32'd0);
        check("rvalid_done", {31'd0, rvalid}, 32'd1);
        check("rdata_done", rdata, got_exp);
`ifdef DMEM_ALIGN_CHECK_EN
        check("misalign_done", {31'd0, misalign}, {31'd0, mis});
`endif
        memread = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        check("stall_idle", {31'd0, stall}, 32'd0);
        check("rvalid_idle", {31'd0, rvalid}, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("misalign_idle", {31'd0, misalign}, 32'd0);
`endif
    endtask

    // Store that is cut off by reset in BUSY cycle number at_busy.
    task automatic store_with_reset(input logic [31:0] a, input logic [31:0] d, input int at_busy);
        @(negedge clk);
        memwrite = 1'b1; addr = a; wdata = d;
        #1;
        check("rst_stall_accept", {31'd0, stall}, 32'd1);
        for (int k = 1; k <= at_busy; k++) begin
            @(negedge clk);
            check("rst_stall_busy", {31'd0, stall}, 32'd1);
        end
        reset = 1'b1; memwrite = 1'b0;
        @(negedge clk);
        model_rdata = 32'd0;
        check("rst_stall_after", {31'd0, stall}, 32'd0);
        check("rst_rvalid_after", {31'd0, rvalid}, 32'd0);
        check("rst_rdata_after", rdata, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < LATENCY + 1; k++) begin
            @(negedge clk);
            check("rst_no_rvalid", {31'd0, rvalid}, 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] d;

        // Reset held for 2 cycles, then idle.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("reset_rdata", rdata, 32'd0);
            check("reset_rvalid", {31'd0, rvalid}, 32'd0);
            check("reset_stall", {31'd0, stall}, 32'd0);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_rdata", rdata, 32'd0);
            check("idle_rvalid", {31'd0, rvalid}, 32'd0);
            check("idle_stall", {31'd0, stall}, 32'd0);
        end

        // Store then load
        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0);

        // Aliasing: 0x104 and 0x004 are the same word
        access(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h0000_0004, 32'h0);

        // Both strobes high behaves as a store
        access(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0);

        // Reset in the first BUSY cycle, then in the last BUSY cycle
        access(1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111);
        store_with_reset(32'h0000_0020, 32'hCAFE_F00D, 1);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        store_with_reset(32'h0000_0020, 32'hCAFE_F00D, LATENCY);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0);

        // Random aligned store/load pairs. High address bits differ between
        // the store and the load.
        for (int i = 0; i < 6; i++) begin
            a = (32'($urandom_range(0, (2**ADDR_W) - 1)) << 2) | ($urandom & 32'hFFFF_FF00);
            d = $urandom;
            access(1'b0, 1'b1, a, d);
            access(1'b1, 1'b0, a ^ 32'h0F00_0000, 32'h0);
        end

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned store is dropped, aligned load sees the old word,
        // misaligned load returns zero.
        access(1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_0BAD);
        access(1'b0, 1'b1, 32'h0000_0022, 32'h0000_0055);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0021, 32'h0);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
